// File: rtl/tex_column_sequencer.sv
// tex_column_sequencer
// Per-column controller for the raycaster texture lookup stage. It takes one
// column descriptor from the DDA stage, walks every screen row of the column
// in order, and streams one RGB565 pixel per row to the framebuffer writer.
// Ceiling and floor rows get flat colours. Solid wall cells get a flat wall
// colour. Textured cells (map value 3..5) get one texture-unit request per
// row, and if the texture unit never answers, the row gets an error colour.
//
// Ports
//   pixel_clk_in, rst_in           : clock, asynchronous active-high reset
//   col_valid_in / col_ready_out   : descriptor handshake (ready only in IDLE)
//   wallX_in, draw_start_in,
//   draw_end_in, map_val_in        : column descriptor fields
//   tex_req_out, tex_wallX_out,
//   tex_vcount_out, tex_sel_out    : request to the texture unit
//   tex_pixel_in, tex_valid_in     : texture unit result
//   pixel_out, pixel_row_out,
//   pixel_valid_out, pixel_ready_in: pixel stream with backpressure
//   col_done_out                   : one-cycle pulse after the last row
//   tex_err_out                    : sticky texture-timeout flag
module tex_column_sequencer #(
  parameter int          SCREEN_HEIGHT = 180,
  parameter logic [15:0] CEIL_COLOR    = 16'h4208,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
  parameter logic [15:0] FLAT_COLOR    = 16'hF800,
  parameter int          TEX_TIMEOUT   = 8,
  parameter logic [15:0] ERR_COLOR     = 16'hF81F
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [15:0] wallX_in,
  input  logic [7:0]  draw_start_in,
  input  logic [7:0]  draw_end_in,
  input  logic [3:0]  map_val_in,
  output logic        tex_req_out,
  output logic [15:0] tex_wallX_out,
  output logic [7:0]  tex_vcount_out,
  output logic [3:0]  tex_sel_out,
  input  logic [15:0] tex_pixel_in,
  input  logic        tex_valid_in,
  output logic [15:0] pixel_out,
  output logic [7:0]  pixel_row_out,
  output logic        pixel_valid_out,
  input  logic        pixel_ready_in,
  output logic        col_done_out,
  output logic        tex_err_out
);

  localparam logic [7:0] LAST_ROW    = 8'(SCREEN_HEIGHT - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TEX_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    TEX_REQ,
    TEX_WAIT,
    EMIT,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [7:0]  row, row_next;
  logic [15:0] pixel, pixel_next;
  logic [7:0]  wait_cnt, wait_next;
  logic        err_set;

  logic [15:0] wall_x;
  logic [7:0]  draw_start, draw_end;
  logic [3:0]  map_val;
  logic        no_wall;
  logic        tex_err;

  logic        capture;
  logic        textured;
  logic [7:0]  end_clamped;

  // The descriptor is sanitised at capture time. This keeps the per-row
  // classification down to two plain comparisons.
  assign end_clamped = (draw_end_in >= LAST_ROW) ? LAST_ROW : draw_end_in;
  assign capture     = col_valid_in && col_ready_out;
  assign textured    = (map_val >= 4'd3) && (map_val <= 4'd5);

  // State register
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Row walk and texture wait. The wait counter holds the number of
  // TEX_WAIT cycles spent so far, which includes the current cycle.
  always_comb begin
    state_next      = state;
    row_next        = row;
    pixel_next      = pixel;
    wait_next       = wait_cnt;
    err_set         = 1'b0;
    // col_ready_out is gated by reset so that it stays low while reset is held.
    col_ready_out   = 1'b0;
    tex_req_out     = 1'b0;
    pixel_valid_out = 1'b0;
    col_done_out    = 1'b0;

    case (state)
      IDLE: begin
        col_ready_out = !rst_in;
        if (capture) begin
          row_next   = 8'd0;
          state_next = ROW;
        end
      end
      ROW: begin
        if (row < draw_start) begin
          pixel_next = CEIL_COLOR;
          state_next = EMIT;
        end else if (no_wall || (row > draw_end)) begin
          pixel_next = FLOOR_COLOR;
          state_next = EMIT;
        end else if (textured) begin
          state_next = TEX_REQ;
        end else begin
          pixel_next = FLAT_COLOR;
          state_next = EMIT;
        end
      end
      TEX_REQ: begin
        tex_req_out = 1'b1;
        wait_next   = 8'd1;
        state_next  = TEX_WAIT;
      end
      TEX_WAIT: begin
        if (tex_valid_in) begin
          pixel_next = tex_pixel_in;
          state_next = EMIT;
        end else if (wait_cnt >= TIMEOUT_CNT) begin
          pixel_next = ERR_COLOR;
          err_set    = 1'b1;
          state_next = EMIT;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      EMIT: begin
        pixel_valid_out = 1'b1;
        if (pixel_ready_in) begin
          if (row == LAST_ROW) begin
            state_next = DONE;
          end else begin
            row_next   = row + 8'd1;
            state_next = ROW;
          end
        end
      end
      DONE: begin
        col_done_out = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. The descriptor is latched only on capture, so it
  // stays constant for the whole column.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      row        <= 8'd0;
      pixel      <= 16'd0;
      wait_cnt   <= 8'd0;
      tex_err    <= 1'b0;
      wall_x     <= 16'd0;
      draw_start <= 8'd0;
      draw_end   <= 8'd0;
      map_val    <= 4'd0;
      no_wall    <= 1'b0;
    end else begin
      row      <= row_next;
      pixel    <= pixel_next;
      wait_cnt <= wait_next;
      if (err_set) begin
        tex_err <= 1'b1;
      end
      if (capture) begin
        wall_x     <= wallX_in;
        draw_start <= draw_start_in;
        draw_end   <= end_clamped;
        map_val    <= map_val_in;
        no_wall    <= (draw_start_in > end_clamped);
      end
    end
  end

  assign tex_wallX_out  = wall_x;
  assign tex_vcount_out = row;
  assign tex_sel_out    = map_val;
  assign pixel_out      = pixel;
  assign pixel_row_out  = row;
  assign tex_err_out    = tex_err;

endmodule

// File: tb/tb_tex_column_sequencer.sv
// tb_tex_column_sequencer
// Scoreboard bench for tex_column_sequencer. Each column descriptor pushes
// its 180 expected (pixel, row) pairs into a queue. A monitor pops and compares
// them whenever a pixel is accepted. A small texture-unit model answers requests
// two cycles later with a row-derived pixel.
module tb_tex_column_sequencer;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        col_valid_in = 1'b0;
  logic        col_ready_out;
  logic [15:0] wallX_in = 16'd0;
  logic [7:0]  draw_start_in = 8'd0;
  logic [7:0]  draw_end_in = 8'd0;
  logic [3:0]  map_val_in = 4'd0;
  logic        tex_req_out;
  logic [15:0] tex_wallX_out;
  logic [7:0]  tex_vcount_out;
  logic [3:0]  tex_sel_out;
  logic [15:0] tex_pixel_in = 16'd0;
  logic        tex_valid_in = 1'b0;
  logic [15:0] pixel_out;
  logic [7:0]  pixel_row_out;
  logic        pixel_valid_out;
  logic        pixel_ready_in = 1'b1;
  logic        col_done_out;
  logic        tex_err_out;

  always #5 clk = ~clk;

  tex_column_sequencer dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_in),
    .col_valid_in    (col_valid_in),
    .col_ready_out   (col_ready_out),
    .wallX_in        (wallX_in),
    .draw_start_in   (draw_start_in),
    .draw_end_in     (draw_end_in),
    .map_val_in      (map_val_in),
    .tex_req_out     (tex_req_out),
    .tex_wallX_out   (tex_wallX_out),
    .tex_vcount_out  (tex_vcount_out),
    .tex_sel_out     (tex_sel_out),
    .tex_pixel_in    (tex_pixel_in),
    .tex_valid_in    (tex_valid_in),
    .pixel_out       (pixel_out),
    .pixel_row_out   (pixel_row_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_ready_in  (pixel_ready_in),
    .col_done_out    (col_done_out),
    .tex_err_out     (tex_err_out)
  );

  typedef struct packed {
    logic [15:0] pix;
    logic [7:0]  row;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          req_cnt = 0;
  int          col_pops = 0;
  bit          tex_enable = 1'b0;
  bit          holding = 1'b0;
  bit          prev_req = 1'b0;
  logic [15:0] held_pix;
  logic [7:0]  held_row;
  logic [7:0]  last_vcount = 8'd0;
  logic [3:0]  last_sel = 4'd0;
  logic [15:0] last_wx = 16'd0;
  logic [7:0]  tex_v;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] tex_fn(input logic [7:0] v);
    return {v, ~v};
  endfunction

  function automatic logic [15:0] exp_color(input int r, input int s, input int e,
                                            input int m, input bit tex_on);
    int ec;
    ec = (e >= 180) ? 179 : e;
    if (r < s) return 16'h4208;
    if ((s > ec) || (r > ec)) return 16'h8410;
    if ((m >= 3) && (m <= 5)) return tex_on ? tex_fn(8'(r)) : 16'hF81F;
    return 16'hF800;
  endfunction

  // Texture unit model: the result strobe arrives in the second wait cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (tex_req_out && tex_enable) begin
        tex_v = tex_vcount_out;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tex_valid_in = 1'b1;
        tex_pixel_in = tex_fn(tex_v);
        @(posedge clk); #1;
        tex_valid_in = 1'b0;
        tex_pixel_in = 16'd0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted pixel, checks hold
  // stability under backpressure, and counts requests and done pulses.
  always @(negedge clk) begin
    if (col_done_out) done_cnt++;
    if (tex_req_out) begin
      req_cnt++;
      last_vcount = tex_vcount_out;
      last_sel    = tex_sel_out;
      last_wx     = tex_wallX_out;
      checkOutput("tex_req single cycle", 32'(prev_req), 32'd0);
    end
    prev_req = tex_req_out;
    if (pixel_valid_out) begin
      if (holding) begin
        checkOutput("held pixel", 32'(pixel_out), 32'(held_pix));
        checkOutput("held row", 32'(pixel_row_out), 32'(held_row));
      end
      if (pixel_ready_in) begin
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected pixel: got row %0d pixel %0h, expected none",
                   pixel_row_out, pixel_out);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput($sformatf("pixel row %0d", mon_e.row), 32'(pixel_out), 32'(mon_e.pix));
          checkOutput("pixel row order", 32'(pixel_row_out), 32'(mon_e.row));
          col_pops++;
        end
      end else begin
        holding  = 1'b1;
        held_pix = pixel_out;
        held_row = pixel_row_out;
      end
    end else begin
      holding = 1'b0;
    end
  end

  // Pushes the expected column and hands the descriptor over. The inputs
  // are scrambled afterwards so that they must have been latched.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] e,
                               input logic [3:0] m, input logic [15:0] wx,
                               input bit tex_on);
    int n;
    exp_q.delete();
    for (int r = 0; r < 180; r++) begin
      exp_q.push_back('{pix: exp_color(r, int'(s), int'(e), int'(m), tex_on), row: 8'(r)});
    end
    tex_enable = tex_on;
    col_pops   = 0;
    n = 0;
    while (!col_ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("col_ready before capture", 32'(col_ready_out), 32'd1);
    col_valid_in  = 1'b1;
    draw_start_in = s;
    draw_end_in   = e;
    map_val_in    = m;
    wallX_in      = wx;
    @(posedge clk); #1;
    col_valid_in  = 1'b0;
    draw_start_in = 8'hFF;
    draw_end_in   = 8'h00;
    map_val_in    = 4'd0;
    wallX_in      = 16'd0;
  endtask

  task automatic waitColumn(input string name);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (!col_done_out && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " done seen"}, 32'(col_done_out), 32'd1);
    @(negedge clk);
    checkOutput({name, " done count"}, 32'(done_cnt), 32'(d0 + 1));
    checkOutput({name, " done one cycle"}, 32'(col_done_out), 32'd0);
    checkOutput({name, " ready after done"}, 32'(col_ready_out), 32'd1);
    checkOutput({name, " pixel count"}, 32'(col_pops), 32'd180);
    checkOutput({name, " queue drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int r0;
    int d0;

    // Reset state
    #3;
    checkOutput("reset col_ready", 32'(col_ready_out), 32'd0);
    checkOutput("reset pixel_valid", 32'(pixel_valid_out), 32'd0);
    checkOutput("reset pixel", 32'(pixel_out), 32'd0);
    checkOutput("reset tex_req", 32'(tex_req_out), 32'd0);
    checkOutput("reset done", 32'(col_done_out), 32'd0);
    checkOutput("reset tex_err", 32'(tex_err_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    #1 checkOutput("ready after release", 32'(col_ready_out), 32'd1);

    // Flat column with a three-cycle stall on row 10
    applyStimulus(8'd60, 8'd119, 4'd1, 16'h0011, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pixel_valid_out && pixel_row_out == 8'd9) && n < 1000);
    checkOutput("reached row 9", 32'(pixel_row_out), 32'd9);
    @(posedge clk); #1;
    pixel_ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall valid", 32'(pixel_valid_out), 32'd1);
    checkOutput("stall row", 32'(pixel_row_out), 32'd10);
    repeat (3) @(posedge clk);
    #1 pixel_ready_in = 1'b1;
    waitColumn("flat");

    // Single textured row
    r0 = req_cnt;
    applyStimulus(8'd90, 8'd90, 4'd4, 16'hBEEF, 1'b1);
    waitColumn("textured");
    checkOutput("tex req count", 32'(req_cnt - r0), 32'd1);
    checkOutput("tex vcount", 32'(last_vcount), 32'd90);
    checkOutput("tex sel", 32'(last_sel), 32'd4);
    checkOutput("tex wallX", 32'(last_wx), 32'hBEEF);
    checkOutput("tex_err clean", 32'(tex_err_out), 32'd0);

    // Texture timeout
    r0 = req_cnt;
    applyStimulus(8'd90, 8'd90, 4'd3, 16'h0042, 1'b0);
    waitColumn("timeout");
    checkOutput("timeout req count", 32'(req_cnt - r0), 32'd1);
    checkOutput("tex_err set", 32'(tex_err_out), 32'd1);

    // Empty wall: no requests, error flag stays sticky
    r0 = req_cnt;
    applyStimulus(8'd100, 8'd50, 4'd4, 16'h0077, 1'b1);
    waitColumn("empty");
    checkOutput("empty req count", 32'(req_cnt - r0), 32'd0);
    checkOutput("tex_err sticky", 32'(tex_err_out), 32'd1);

    // Clamped wall end
    applyStimulus(8'd150, 8'd250, 4'd2, 16'h0099, 1'b0);
    waitColumn("clamped");

    // Reset while waiting on the texture unit at row 37
    applyStimulus(8'd37, 8'd60, 4'd5, 16'h1357, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tex_req_out && tex_vcount_out == 8'd37) && n < 2000);
    checkOutput("reached row 37 req", 32'(tex_vcount_out), 32'd37);
    d0 = done_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_in = 1'b1;
    #1;
    checkOutput("midreset col_ready", 32'(col_ready_out), 32'd0);
    checkOutput("midreset pixel_valid", 32'(pixel_valid_out), 32'd0);
    checkOutput("midreset pixel", 32'(pixel_out), 32'd0);
    checkOutput("midreset row", 32'(pixel_row_out), 32'd0);
    checkOutput("midreset tex_req", 32'(tex_req_out), 32'd0);
    checkOutput("midreset vcount", 32'(tex_vcount_out), 32'd0);
    checkOutput("midreset sel", 32'(tex_sel_out), 32'd0);
    checkOutput("midreset wallX", 32'(tex_wallX_out), 32'd0);
    checkOutput("midreset tex_err", 32'(tex_err_out), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    #1 checkOutput("ready after midreset", 32'(col_ready_out), 32'd1);
    checkOutput("no done on abort", 32'(done_cnt), 32'(d0));

    // Fresh column after the abort starts again at row 0
    applyStimulus(8'd0, 8'd179, 4'd2, 16'h2468, 1'b0);
    waitColumn("after reset");
    checkOutput("tex_err after reset", 32'(tex_err_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
